// File: rtl/t_lane_copy_sched_pkg.sv
// Shared types and constants for the lane-copy scheduler.
package t_lane_copy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_e;

  localparam int LANE_W_DEFAULT = 64;

endpackage

// File: rtl/t_lane_copy_sched_if.sv
// Request/grant and sweep status bundle for the lane-copy scheduler.
interface t_lane_copy_sched_if #(
  parameter int N = 4
);
  localparam int LW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          sweep_start;
  logic          sweep_busy;
  logic          sweep_done;
  logic          upd_valid;
  logic [LW-1:0] upd_lane;

  modport master (
    output req,
    output sweep_start,
    input  gnt,
    input  sweep_busy,
    input  sweep_done,
    input  upd_valid,
    input  upd_lane
  );

  modport slave (
    input  req,
    input  sweep_start,
    output gnt,
    output sweep_busy,
    output sweep_done,
    output upd_valid,
    output upd_lane
  );

endinterface

// File: rtl/t_lane_copy_sched_arb.sv
// Combinational rotate-priority pick: first set req bit from ptr upward.
module t_lane_rr_arb #(
  parameter  int N  = 4,
  localparam int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t_lane_copy_sched.sv
// Lane-copy scheduler: round-robin single-lane copy or full index sweep.
// Optional parity tracking via T_LANE_COPY_SCHED_PARITY_EN.
module t_lane_copy_sched
  import t_lane_copy_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = LANE_W_DEFAULT,
  localparam int LW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  t_lane_copy_sched_if.slave bus,
  input  logic [W-1:0] iv [N-1:0],
`ifdef T_LANE_COPY_SCHED_PARITY_EN
  input  logic         par_chk,
  output logic [N-1:0] ov_par,
  output logic         par_err,
`endif
  output logic [W-1:0] ov [N-1:0]
);

  state_e        state, state_d;
  logic [LW-1:0] ptr;
  logic [LW-1:0] sweep_idx;
  logic [N-1:0]  gnt;
  logic [LW-1:0] g_idx;
  logic          arb_en;
  logic          wr_en;
  logic [LW-1:0] wr_lane;
  logic          sweep_last;

  assign arb_en = rst_n && (state == IDLE) && !bus.sweep_start;
  assign sweep_last = (sweep_idx == LW'(N - 1));

  t_lane_rr_arb #(.N(N)) u_arb (
    .req (bus.req),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign bus.gnt = gnt;

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++)
      if (gnt[i]) g_idx = LW'(i);
  end

  always_comb begin
    state_d = state;
    wr_en   = 1'b0;
    wr_lane = '0;
    unique case (state)
      IDLE: begin
        wr_en   = |gnt;
        wr_lane = g_idx;
        if (bus.sweep_start) state_d = SWEEP;
      end
      SWEEP: begin
        wr_en   = 1'b1;
        wr_lane = sweep_idx;
        if (sweep_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      sweep_idx      <= '0;
      bus.upd_valid  <= 1'b0;
      bus.upd_lane   <= '0;
      bus.sweep_busy <= 1'b0;
      bus.sweep_done <= 1'b0;
      for (int i = 0; i < N; i++)
        ov[i] <= '0;
    end else begin
      state          <= state_d;
      bus.sweep_busy <= (state != IDLE);
      bus.sweep_done <= (state == DONE);
      bus.upd_valid  <= wr_en;
      if (wr_en) bus.upd_lane <= wr_lane;
      for (int i = 0; i < N; i++)
        if (wr_en && wr_lane == LW'(i))
          ov[i] <= iv[i];
      if (state == IDLE && |gnt)
        ptr <= (g_idx == LW'(N - 1)) ? '0 : g_idx + LW'(1);
      if (state == SWEEP)
        sweep_idx <= sweep_last ? '0 : sweep_idx + LW'(1);
      else if (state == IDLE)
        sweep_idx <= '0;
    end
  end

`ifdef T_LANE_COPY_SCHED_PARITY_EN
  logic [N-1:0] par_bad;

  always_comb begin
    par_bad = '0;
    for (int i = 0; i < N; i++)
      par_bad[i] = ov_par[i] ^ (^ov[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_par  <= '0;
      par_err <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (wr_en && wr_lane == LW'(i))
          ov_par[i] <= ^iv[i];
      if (par_chk && |par_bad) par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_t_lane_copy_sched.sv
// Directed bench for t_lane_copy_sched with an update scoreboard.
module tb_t_lane_copy_sched;
  import t_lane_copy_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int LW = 2;

  typedef struct {
    logic [LW-1:0] lane;
    logic [W-1:0]  data;
  } upd_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] iv [N-1:0];
  logic [W-1:0] ov [N-1:0];
  logic [W-1:0] mov [N];
  upd_t         sbq [$];
  int           checks = 0;
  int           errors = 0;

`ifdef T_LANE_COPY_SCHED_PARITY_EN
  logic         par_chk;
  logic [N-1:0] ov_par;
  logic         par_err;
`endif

  t_lane_copy_sched_if #(.N(N)) bus();

  t_lane_copy_sched #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .iv      (iv),
`ifdef T_LANE_COPY_SCHED_PARITY_EN
    .par_chk (par_chk),
    .ov_par  (ov_par),
    .par_err (par_err),
`endif
    .ov      (ov)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int lane_of(logic [N-1:0] v);
    int l = 0;
    for (int i = 0; i < N; i++)
      if (v[i]) l = i;
    return l;
  endfunction

  task automatic bank_chk();
    for (int i = 0; i < N; i++)
      chk($sformatf("ov[%0d]", i), ov[i], mov[i]);
  endtask

  // One cycle: drive, check comb grant, push expectation,
  // then after the edge pop and compare the reported update.
  task automatic cyc(logic [N-1:0] r, logic ss,
                     logic [N-1:0] eg, logic ev, int el,
                     logic eb, logic ed);
    upd_t u;
    bus.req = r;
    bus.sweep_start = ss;
    #1;
    chk("gnt", bus.gnt, eg);
    if (ev) sbq.push_back('{lane: LW'(el), data: iv[el]});
    @(posedge clk);
    #1;
    chk("upd_valid", bus.upd_valid, ev);
    if (bus.upd_valid && sbq.size() != 0) begin
      u = sbq.pop_front();
      chk("upd_lane", bus.upd_lane, u.lane);
      mov[u.lane] = u.data;
    end
    bank_chk();
    chk("sweep_busy", bus.sweep_busy, eb);
    chk("sweep_done", bus.sweep_done, ed);
    bus.sweep_start = 1'b0;
  endtask

  task automatic arb(logic [N-1:0] r, logic [N-1:0] eg);
    cyc(r, 1'b0, eg, eg != '0, lane_of(eg), 1'b0, 1'b0);
  endtask

  task automatic rst_cyc(logic [N-1:0] r);
    rst_n = 1'b0;
    bus.req = r;
    bus.sweep_start = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, '0);
    @(posedge clk);
    #1;
    sbq.delete();
    for (int i = 0; i < N; i++) mov[i] = '0;
    bank_chk();
    chk("rst_upd_valid", bus.upd_valid, 1'b0);
    chk("rst_upd_lane", bus.upd_lane, '0);
    chk("rst_busy", bus.sweep_busy, 1'b0);
    chk("rst_done", bus.sweep_done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    bus.sweep_start = 1'b0;
`ifdef T_LANE_COPY_SCHED_PARITY_EN
    par_chk = 1'b1;
`endif
    for (int i = 0; i < N; i++) begin
      iv[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
      mov[i] = '0;
    end

    repeat (3) rst_cyc(4'b1111);
    rst_n = 1'b1;

    iv[2] = 64'hDEAD_BEEF_0000_0002;
    arb(4'b0100, 4'b0100);
    arb(4'b1111, 4'b1000);

    rst_cyc(4'b1111);
    rst_n = 1'b1;
    repeat (2) begin
      arb(4'b1111, 4'b0001);
      arb(4'b1111, 4'b0010);
      arb(4'b1111, 4'b0100);
      arb(4'b1111, 4'b1000);
    end

    arb(4'b0100, 4'b0100);
    arb(4'b0011, 4'b0001);
    arb(4'b0010, 4'b0010);
    arb(4'b0000, 4'b0000);

    for (int k = 0; k < N; k++)
      iv[k] = 64'(k) * 64'h1111;
    cyc(4'b1111, 1'b1, '0, 1'b0, 0, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, '0, 1'b1, 0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, '0, 1'b1, 1, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, '0, 1'b1, 2, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, '0, 1'b1, 3, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, '0, 1'b0, 0, 1'b1, 1'b1);
    arb(4'b1111, 4'b0100);
    arb(4'b1111, 4'b1000);

    for (int k = 0; k < N; k++)
      iv[k] = 64'hA5A5_0000_0000_0000 | 64'(k + 1);
    cyc(4'b0000, 1'b1, '0, 1'b0, 0, 1'b0, 1'b0);
    cyc(4'b0000, 1'b0, '0, 1'b1, 0, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, '0, 1'b1, 1, 1'b1, 1'b0);
    rst_cyc(4'b0000);
    rst_n = 1'b1;
    repeat (2)
      cyc(4'b0000, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);

    cyc(4'b0000, 1'b1, '0, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < N; k++)
      cyc(4'b0000, 1'b0, '0, 1'b1, k, 1'b1, 1'b0);
    cyc(4'b0000, 1'b0, '0, 1'b0, 0, 1'b1, 1'b1);
    arb(4'b0000, 4'b0000);
    arb(4'b0010, 4'b0010);

`ifdef T_LANE_COPY_SCHED_PARITY_EN
    for (int i = 0; i < N; i++)
      chk("ov_par", ov_par[i], ^mov[i]);
    chk("par_err", par_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t_lane_copy_sched.md
Name: t_lane_copy_sched

Overview:
- Scheduler that shares one lane-copy datapath among N requesters.
- The datapath is an N-lane, W-bit register bank: ov[i] <= iv[i] on clk.
- Normal mode: a round-robin arbiter grants at most one requesting lane per cycle and copies that lane into its ov slot.
- Sweep mode: a start pulse copies every lane in index order, then returns to arbitration.

Parameters:
N, 4, number of lanes/requesters (N >= 2)
W, 64, lane data width
LW, $clog2(N), lane index width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  reset, synchronous, active-low
iv  input  [W-1:0] x [N-1:0] unpacked  per-lane source data
req  input  N  per-lane copy request; held by requester until granted
gnt  output  N  one-hot grant, combinational, valid in the cycle req is sampled
sweep_start  input  1  single-cycle pulse; begin full sweep
sweep_busy  output  1  registered; high while state != IDLE
sweep_done  output  1  registered; one-cycle pulse at sweep completion
ov  output  [W-1:0] x [N-1:0] unpacked  lane register bank
upd_valid  output  1  registered; a lane of ov changed on the previous edge
upd_lane  output  LW  index of that lane; holds last value when upd_valid=0

Behaviour:
- Reset: while rst_n=0 at a posedge:
  - state=IDLE, ptr=0, sweep_idx=0.
  - Every ov[i]=0; upd_valid=0, upd_lane=0, sweep_busy=0, sweep_done=0.
  - gnt is forced to 0 whenever rst_n=0.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - If sweep_start=1: gnt=0, next state SWEEP with sweep_idx=0. Sweep has priority; req is ignored that cycle.
  - Otherwise, if req!=0: gnt = first set bit of req searching ptr, ptr+1, ... with wrap mod N.
  - At the edge: ov[g] <= iv[g], ptr <= (g+1) mod N, upd_valid<=1, upd_lane<=g.
  - If req=0: gnt=0, ptr unchanged, upd_valid<=0.
- SWEEP:
  - gnt=0; req and sweep_start are ignored.
  - Each cycle: ov[sweep_idx] <= iv[sweep_idx], upd_valid<=1, upd_lane<=sweep_idx.
  - At sweep_idx==N-1: next state DONE; otherwise sweep_idx+1.
  - Sweep length is exactly N cycles; ptr is not modified.
- DONE: one cycle; gnt=0, sweep_done=1 (sweep_busy=1), upd_valid<=0; next state IDLE.
- Latency:
  - Request to grant: 0 cycles.
  - Grant to ov/upd_valid visible: 1 cycle.
  - sweep_start to sweep_done: N+2 cycles.
- Only the granted/swept lane updates; all other ov lanes hold.
- Simultaneous events:
  - sweep_start in SWEEP/DONE is dropped (no queuing).
  - A requester whose req is high during a sweep stays pending and competes on return to IDLE.
- Reset asserted mid-sweep: the full reset state applies on that edge; sweep_done does not pulse.

Optional Feature:
- Macro: T_LANE_COPY_SCHED_PARITY_EN.
- Defined:
  - Adds output ov_par [N-1:0], registered, reset 0.
  - ov_par[i] = ^ov[i] (even parity), updated on the same edge and under the same condition as ov[i].
  - Adds input par_chk (1 bit). When high, an error is flagged on mismatch between ov_par and recomputed parity of ov: output par_err (1 bit, registered, sticky until reset).
- Undefined: ov_par, par_chk and par_err ports and all parity logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package t_lane_copy_pkg holds:
  - the state_e enum (IDLE, SWEEP, DONE);
  - the LANE_W_DEFAULT=64 constant.
- One sub-module: t_lane_rr_arb (parameter N; inputs req, ptr, en; output one-hot gnt).
  - Purely combinational rotate-priority pick; gnt=0 when en=0.
- The FSM, ptr, sweep counter and ov bank live in the top module. The ov bank uses a for loop over an integer index inside the clocked block.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with iv[i]=64'hFFFF_FFFF_FFFF_FFFF and req=4'b1111 -> gnt=0, all ov=0, upd_valid=0, sweep_busy=0.
2. Single request: req=4'b0100, iv[2]=64'hDEAD_BEEF_0000_0002.
   - Same cycle: gnt=4'b0100.
   - Next cycle: ov[2]=64'hDEAD_BEEF_0000_0002, upd_valid=1, upd_lane=2; other lanes unchanged; ptr=3.
3. Fairness: from reset, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
4. Wrap-around: set ptr=3 (grant lane 2), then req=4'b0011 -> gnt=0001, then with req=4'b0010 -> gnt=0010.
5. Sweep: iv[k]=k*64'h1111, req=4'b1111 held, sweep_start pulse.
   - gnt=0 for 6 cycles.
   - ov[0..3] update one per cycle, with upd_lane=0,1,2,3.
   - sweep_done pulses at cycle 6; arbitration resumes from the pre-sweep ptr.
6. Reset mid-sweep: rst_n=0 after lanes 0-1 are copied -> all ov=0, sweep_busy=0 next cycle, sweep_done never asserts. A new sweep_start after reset completes normally.
